// File: rtl/maze_mover_pkg.sv
// Shared types and constants for the maze sprite mover.
package maze_mover_pkg;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ADDR  = 3'd2,
        ST_CHECK = 3'd3,
        ST_STEP  = 3'd4
    } state_t;

    // Bit positions inside the 4-bit wall word from the level ROM.
    localparam int WALL_TOP   = 3;
    localparam int WALL_BOT   = 2;
    localparam int WALL_LEFT  = 1;
    localparam int WALL_RIGHT = 0;

    localparam logic [10:0] MAZE_Y0 = 11'd100;
    localparam logic [3:0]  SPR     = 4'd8;

    function automatic dir_t opposite_dir(input dir_t d);
        case (d)
            DIR_UP:    return DIR_DOWN;
            DIR_DOWN:  return DIR_UP;
            DIR_LEFT:  return DIR_RIGHT;
            DIR_RIGHT: return DIR_LEFT;
            default:   return DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/maze_mover_dir_arbiter.sv
// Button priority encoder and buffered (pending) turn request.
module dir_arbiter
    import maze_mover_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic btn_u,
    input  logic btn_d,
    input  logic btn_l,
    input  logic btn_r,
    input  logic capture_en,
    input  logic clear,
    input  logic consume,
    input  dir_t cur_dir,
    output dir_t pend_dir,
    output logic pend_opposite
);

    dir_t btn_dir;
    dir_t pend_d;
    dir_t pend_q;

    // Fixed priority U > D > L > R.
    always_comb begin
        btn_dir = DIR_NONE;
        if (btn_u)      btn_dir = DIR_UP;
        else if (btn_d) btn_dir = DIR_DOWN;
        else if (btn_l) btn_dir = DIR_LEFT;
        else if (btn_r) btn_dir = DIR_RIGHT;
    end

    // A held button wins over consumption, so a held key stays requested.
    always_comb begin
        pend_d = pend_q;
        if (clear)
            pend_d = DIR_NONE;
        else if (capture_en && (btn_dir != DIR_NONE))
            pend_d = btn_dir;
        else if (consume)
            pend_d = DIR_NONE;
    end

    // Pending-direction register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend_q <= DIR_NONE;
        else     pend_q <= pend_d;
    end

    assign pend_dir      = pend_q;
    assign pend_opposite = (cur_dir != DIR_NONE) && (pend_q == opposite_dir(cur_dir));

endmodule

// File: rtl/maze_mover.sv
// Steps the 8x8 sprite through the level tile grid once per frame tick.
//
// state | meaning
// INIT  | load spawn tile and centre offsets
// IDLE  | wait for a frame tick (or a buffered one)
// ADDR  | wall lookup settling for the current tile
// CHECK | turn / block decision
// STEP  | move one pixel along cur_dir
module maze_mover
    import maze_mover_pkg::*;
#(
    parameter logic [4:0] START_COL = 5'd1,
    parameter logic [4:0] START_ROW = 5'd1,
    parameter logic [2:0] STEP_PX   = 3'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        btn_u,
    input  logic        btn_d,
    input  logic        btn_l,
    input  logic        btn_r,
    input  logic [1:0]  level_select,
    input  logic [9:0]  tile_w,
    input  logic [9:0]  tile_h,
    input  logic [4:0]  num_cols,
    input  logic [4:0]  num_rows,
    input  logic [3:0]  walls,
    output logic [4:0]  tile_row,
    output logic [4:0]  tile_col,
    output logic [10:0] blkpos_x,
    output logic [10:0] blkpos_y,
    output logic        moving,
    output logic        busy
);

    state_t      state_q, state_d;
    dir_t        cur_dir_q, cur_dir_d, eff_dir, pend_dir;
    logic        pend_opp, consume;
    logic [2:0]  steps_q, steps_d;
    logic        tick_pend_q, tick_pend_d;
    logic [1:0]  level_q;
    logic [4:0]  tile_col_q, tile_col_d, tile_row_q, tile_row_d;
    logic [9:0]  x_off_q, x_off_d, y_off_q, y_off_d, cx, cy;
    logic [10:0] base_x_q, base_x_d, base_y_q, base_y_d;
    logic [10:0] blkpos_x_q, blkpos_x_d, blkpos_y_q, blkpos_y_d;
    logic        moving_q, moving_d, busy_q, busy_d;
    logic        level_chg, aligned;
    logic [3:0]  blocked;

    assign cx        = (tile_w - {6'd0, SPR}) >> 1;
    assign cy        = (tile_h - {6'd0, SPR}) >> 1;
    assign aligned   = (x_off_q == cx) && (y_off_q == cy);
    assign level_chg = (level_select != level_q);

    // Grid edges behave like walls.
    assign blocked[WALL_TOP]   = walls[WALL_TOP]   | (tile_row_q == 5'd0);
    assign blocked[WALL_BOT]   = walls[WALL_BOT]   | (tile_row_q == num_rows - 5'd1);
    assign blocked[WALL_LEFT]  = walls[WALL_LEFT]  | (tile_col_q == 5'd0);
    assign blocked[WALL_RIGHT] = walls[WALL_RIGHT] | (tile_col_q == num_cols - 5'd1);

    // NONE counts as blocked so "no direction" and "walled" share one path.
    function automatic logic dir_blocked(input dir_t d, input logic [3:0] b);
        case (d)
            DIR_UP:    return b[WALL_TOP];
            DIR_DOWN:  return b[WALL_BOT];
            DIR_LEFT:  return b[WALL_LEFT];
            DIR_RIGHT: return b[WALL_RIGHT];
            default:   return 1'b1;
        endcase
    endfunction

    dir_arbiter u_arb (
        .clk           (clk),
        .rst           (rst),
        .btn_u         (btn_u),
        .btn_d         (btn_d),
        .btn_l         (btn_l),
        .btn_r         (btn_r),
        .capture_en    (state_q != ST_INIT),
        .clear         (state_q == ST_INIT),
        .consume       (consume),
        .cur_dir       (cur_dir_q),
        .pend_dir      (pend_dir),
        .pend_opposite (pend_opp)
    );

    // Next-state, counter and output computation.
    always_comb begin
        state_d     = state_q;
        cur_dir_d   = cur_dir_q;
        eff_dir     = cur_dir_q;
        consume     = 1'b0;
        steps_d     = steps_q;
        tick_pend_d = tick_pend_q;
        tile_col_d  = tile_col_q;
        tile_row_d  = tile_row_q;
        x_off_d     = x_off_q;
        y_off_d     = y_off_q;
        base_x_d    = base_x_q;
        base_y_d    = base_y_q;
        moving_d    = moving_q;

        if (frame_tick && (state_q != ST_IDLE))
            tick_pend_d = 1'b1;

        case (state_q)
            ST_INIT: begin
                tile_col_d = START_COL;
                tile_row_d = START_ROW;
                x_off_d    = cx;
                y_off_d    = cy;
                base_x_d   = 11'(START_COL) * {1'b0, tile_w};
                base_y_d   = MAZE_Y0 + 11'(START_ROW) * {1'b0, tile_h};
                cur_dir_d  = DIR_NONE;
                moving_d   = 1'b0;
                state_d    = ST_IDLE;
            end
            ST_IDLE: begin
                if (frame_tick || tick_pend_q) begin
                    steps_d     = STEP_PX;
                    tick_pend_d = 1'b0;
                    state_d     = ST_ADDR;
                end
            end
            ST_ADDR: state_d = ST_CHECK;
            ST_CHECK: begin
                if (aligned) begin
                    if (!dir_blocked(pend_dir, blocked)) begin
                        eff_dir = pend_dir;
                        consume = 1'b1;
                    end
                    cur_dir_d = eff_dir;
                    if (dir_blocked(eff_dir, blocked)) begin
                        moving_d = 1'b0;
                        steps_d  = 3'd0;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d = ST_STEP;
                    end
                end else begin
                    if (pend_opp) begin
                        cur_dir_d = pend_dir;
                        consume   = 1'b1;
                    end
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                case (cur_dir_q)
                    DIR_RIGHT: begin
                        if (x_off_q == tile_w - 10'd1) begin
                            x_off_d    = 10'd0;
                            tile_col_d = tile_col_q + 5'd1;
                            base_x_d   = base_x_q + {1'b0, tile_w};
                        end else x_off_d = x_off_q + 10'd1;
                    end
                    DIR_LEFT: begin
                        if (x_off_q == 10'd0) begin
                            x_off_d    = tile_w - 10'd1;
                            tile_col_d = tile_col_q - 5'd1;
                            base_x_d   = base_x_q - {1'b0, tile_w};
                        end else x_off_d = x_off_q - 10'd1;
                    end
                    DIR_DOWN: begin
                        if (y_off_q == tile_h - 10'd1) begin
                            y_off_d    = 10'd0;
                            tile_row_d = tile_row_q + 5'd1;
                            base_y_d   = base_y_q + {1'b0, tile_h};
                        end else y_off_d = y_off_q + 10'd1;
                    end
                    DIR_UP: begin
                        if (y_off_q == 10'd0) begin
                            y_off_d    = tile_h - 10'd1;
                            tile_row_d = tile_row_q - 5'd1;
                            base_y_d   = base_y_q - {1'b0, tile_h};
                        end else y_off_d = y_off_q - 10'd1;
                    end
                    default: ;
                endcase
                moving_d = 1'b1;
                steps_d  = steps_q - 3'd1;
                state_d  = (steps_q == 3'd1) ? ST_IDLE : ST_ADDR;
            end
            default: state_d = ST_INIT;
        endcase

        // A level switch overrides everything and re-spawns.
        if (level_chg) begin
            state_d     = ST_INIT;
            tick_pend_d = 1'b0;
            steps_d     = 3'd0;
        end

        blkpos_x_d = base_x_d + {1'b0, x_off_d};
        blkpos_y_d = base_y_d + {1'b0, y_off_d};
        busy_d     = (state_d != ST_IDLE);
    end

    // State, counter and registered-output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            cur_dir_q   <= DIR_NONE;
            steps_q     <= 3'd0;
            tick_pend_q <= 1'b0;
            level_q     <= 2'd0;
            tile_col_q  <= 5'd0;
            tile_row_q  <= 5'd0;
            x_off_q     <= 10'd0;
            y_off_q     <= 10'd0;
            base_x_q    <= 11'd0;
            base_y_q    <= 11'd0;
            blkpos_x_q  <= 11'd0;
            blkpos_y_q  <= 11'd0;
            moving_q    <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cur_dir_q   <= cur_dir_d;
            steps_q     <= steps_d;
            tick_pend_q <= tick_pend_d;
            level_q     <= level_select;
            tile_col_q  <= tile_col_d;
            tile_row_q  <= tile_row_d;
            x_off_q     <= x_off_d;
            y_off_q     <= y_off_d;
            base_x_q    <= base_x_d;
            base_y_q    <= base_y_d;
            blkpos_x_q  <= blkpos_x_d;
            blkpos_y_q  <= blkpos_y_d;
            moving_q    <= moving_d;
            busy_q      <= busy_d;
        end
    end

    assign tile_row = tile_row_q;
    assign tile_col = tile_col_q;
    assign blkpos_x = blkpos_x_q;
    assign blkpos_y = blkpos_y_q;
    assign moving   = moving_q;
    assign busy     = busy_q;

endmodule
